// File: rtl/dm_store_buffer.sv
// dm_store_buffer: posted-write store queue in front of the word-addressed data
// memory. Committed stores are queued and then drained one per cycle into the
// memory write port. Loads see byte-accurate data: queued store bytes are merged
// over the memory read word, and the youngest writer of each byte wins.
module dm_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wd,
  input  logic [3:0]  st_be,
  input  logic [31:0] st_pc,

  output logic        dm_we,
  input  logic        dm_ready,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_pc,

  input  logic [31:0] ld_addr,
  input  logic [31:0] dm_rd,
  output logic [31:0] ld_data,

  output logic        empty,
  output logic        full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // Queue storage, one slot per entry.
  logic [29:0] waddr_q [DEPTH];
  logic [31:0] wd_q    [DEPTH];
  logic [3:0]  be_q    [DEPTH];
  logic [31:0] pc_q    [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic push;
  logic pop;

  // Byte offsets are not part of the word address.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

  // Status comes only from the registered count, so it cannot glitch.
  assign empty    = (count == '0);
  assign full     = (count == CNT_FULL);
  assign st_ready = !full;
  assign dm_we    = !empty;

  // A pop in the same cycle does not make room for a push: st_ready looks only
  // at the current count.
  assign push = st_valid && st_ready;
  assign pop  = dm_we && dm_ready;

  // The write port is driven straight from the head slot registers.
  assign dm_addr = {waddr_q[head], 2'b00};
  assign dm_wd   = wd_q[head];
  assign dm_be   = be_q[head];
  assign dm_pc   = pc_q[head];

  // Entry storage: the tail slot is written on push; reset clears every slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        waddr_q[i] <= '0;
        wd_q[i]    <= '0;
        be_q[i]    <= '0;
        pc_q[i]    <= '0;
      end
    end else if (push) begin
      waddr_q[tail] <= st_addr[31:2];
      wd_q[tail]    <= st_wd;
      be_q[tail]    <= st_be;
      pc_q[tail]    <= st_pc;
    end
  end

  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
  // naturally at their width.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_ONE;
      if (pop)  head <= head + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Slots in age order (oldest first) and whether each one holds a live store.
  logic [PW-1:0] ord_idx [DEPTH];
  logic          ord_vld [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_ord
    assign ord_idx[g] = head + PW'(g);
    assign ord_vld[g] = (CW'(g) < count);
  end

  // Load forwarding: start from the memory word, then let each matching entry
  // overwrite its enabled byte lanes, oldest to youngest, so the youngest
  // writer of each byte wins. The head stays a source in the cycle it pops,
  // because the memory has not committed it yet.
  always_comb begin
    ld_data = dm_rd;
    for (int i = 0; i < DEPTH; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (ord_vld[i] && (waddr_q[ord_idx[i]] == ld_addr[31:2]) && be_q[ord_idx[i]][b]) begin
          ld_data[8*b +: 8] = wd_q[ord_idx[i]][8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed bench for dm_store_buffer. Every accepted store is pushed to a
// scoreboard queue; each memory write seen on the dm_* port is popped and compared.
module tb_dm_store_buffer;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_wd;
  logic [3:0]  st_be;
  logic [31:0] st_pc;
  logic        dm_we;
  logic        dm_ready;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [3:0]  dm_be;
  logic [31:0] dm_pc;
  logic [31:0] ld_addr;
  logic [31:0] dm_rd;
  logic [31:0] ld_data;
  logic        empty;
  logic        full;

  int checks = 0;
  int errors = 0;

  // {addr, wd, be, pc}
  logic [99:0] sb[$];

  dm_store_buffer #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .st_addr  (st_addr),
    .st_wd    (st_wd),
    .st_be    (st_be),
    .st_pc    (st_pc),
    .dm_we    (dm_we),
    .dm_ready (dm_ready),
    .dm_addr  (dm_addr),
    .dm_wd    (dm_wd),
    .dm_be    (dm_be),
    .dm_pc    (dm_pc),
    .ld_addr  (ld_addr),
    .dm_rd    (dm_rd),
    .ld_data  (ld_data),
    .empty    (empty),
    .full     (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one accepted store for one cycle and record it as an expected write.
  task automatic do_store(input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] pc);
    st_valid = 1'b1;
    st_addr  = a;
    st_wd    = wd;
    st_be    = be;
    st_pc    = pc;
    sb.push_back({a & 32'hFFFF_FFFC, wd, be, pc});
    @(posedge clk);
    #1;
    st_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Write-port monitor: a write presented with dm_ready high commits on the
  // next rising edge, so it is sampled on the falling edge before it.
  always @(negedge clk) begin
    if (rst === 1'b1 && dm_we === 1'b1 && dm_ready === 1'b1) begin
      logic [99:0] exp;
      logic [99:0] obs;
      obs = {dm_addr, dm_wd, dm_be, dm_pc};
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL dm_write_unexpected: observed %h expected no write", obs);
      end
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        checks++;
        assert (obs === exp) else begin
          errors++;
          $error("FAIL dm_write: observed %h expected %h", obs, exp);
        end
      end
    end
  end

  initial begin
    rst      = 1'b0;
    st_valid = 1'b0;
    st_addr  = '0;
    st_wd    = '0;
    st_be    = '0;
    st_pc    = '0;
    dm_ready = 1'b0;
    ld_addr  = 32'h0;
    dm_rd    = 32'h1234_5678;

    // Reset values
    #1;
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_dm_we",    32'(dm_we),    32'd0);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_dm_addr",  dm_addr,       32'h0);
    chk("rst_dm_wd",    dm_wd,         32'h0);
    chk("rst_dm_be",    32'(dm_be),    32'h0);
    chk("rst_dm_pc",    dm_pc,         32'h0);
    chk("rst_ld_data",  ld_data,       32'h1234_5678);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycles(1);

    // Single store, one write cycle
    dm_ready = 1'b1;
    do_store(32'h10, 32'h1122_3344, 4'hF, 32'h0000_1000);
    chk("t1_dm_we",   32'(dm_we), 32'd1);
    chk("t1_dm_addr", dm_addr,    32'h10);
    chk("t1_dm_wd",   dm_wd,      32'h1122_3344);
    cycles(1);
    chk("t1_dm_we_off", 32'(dm_we), 32'd0);
    chk("t1_empty",     32'(empty), 32'd1);

    // Fill to full, reject a fifth store, drain in order
    dm_ready = 1'b0;
    do_store(32'h0, 32'hA000_0000, 4'hF, 32'h2000);
    do_store(32'h5, 32'hA000_0004, 4'h3, 32'h2004);
    do_store(32'h8, 32'hA000_0008, 4'hC, 32'h2008);
    do_store(32'hC, 32'hA000_000C, 4'h1, 32'h200C);
    chk("t2_full",     32'(full),     32'd1);
    chk("t2_st_ready", 32'(st_ready), 32'd0);
    st_valid = 1'b1;
    st_addr  = 32'h40;
    st_wd    = 32'hDEAD_BEEF;
    st_be    = 4'hF;
    st_pc    = 32'h2010;
    cycles(1);
    st_valid = 1'b0;
    chk("t2_full_hold", 32'(full), 32'd1);
    chk("t2_head_addr", dm_addr,   32'h0);
    dm_ready = 1'b1;
    cycles(4);
    chk("t2_drained", 32'(empty), 32'd1);

    // Byte merge over the memory word, including an empty-enable store
    dm_ready = 1'b0;
    dm_rd    = 32'hAAAA_AAAA;
    do_store(32'h20, 32'h0000_00BB, 4'b0001, 32'h3000);
    do_store(32'h20, 32'hCC00_0000, 4'b1000, 32'h3004);
    do_store(32'h20, 32'h0000_DD00, 4'b0010, 32'h3008);
    ld_addr = 32'h20;
    #1;
    chk("t3_merge", ld_data, 32'hCCAA_DDBB);
    ld_addr = 32'h24;
    #1;
    chk("t3_other_word", ld_data, 32'hAAAA_AAAA);
    do_store(32'h20, 32'hFFFF_FFFF, 4'b0000, 32'h300C);
    ld_addr = 32'h22;
    #1;
    chk("t3_be0_lowbits", ld_data, 32'hCCAA_DDBB);
    dm_ready = 1'b1;
    cycles(4);
    chk("t3_drained", 32'(empty), 32'd1);
    ld_addr = 32'h20;
    #1;
    chk("t3_after_drain", ld_data, 32'hAAAA_AAAA);

    // Youngest writer wins, head still forwards while popping
    dm_ready = 1'b0;
    dm_rd    = 32'h0;
    do_store(32'h30, 32'h1111_1111, 4'hF, 32'h4000);
    do_store(32'h30, 32'h2222_2222, 4'hF, 32'h4004);
    ld_addr = 32'h30;
    #1;
    chk("t4_youngest", ld_data, 32'h2222_2222);
    dm_ready = 1'b1;
    #1;
    chk("t4_pop_cycle", ld_data, 32'h2222_2222);
    @(posedge clk);
    #1;
    dm_ready = 1'b0;
    chk("t4_after_pop",  ld_data, 32'h2222_2222);
    chk("t4_head_wd",    dm_wd,   32'h2222_2222);
    dm_rd = 32'h5555_5555;
    ld_addr = 32'h34;
    #1;
    chk("t4_miss", ld_data, 32'h5555_5555);
    dm_ready = 1'b1;
    cycles(1);
    chk("t4_drained", 32'(empty), 32'd1);

    // Simultaneous push and pop at count 2, pointers wrap several times
    dm_ready = 1'b0;
    do_store(32'h100, 32'hB000_0000, 4'hF, 32'h5000);
    do_store(32'h104, 32'hB000_0001, 4'hF, 32'h5004);
    dm_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      do_store(32'h108 + 32'(4 * k), 32'hB000_0002 + 32'(k), 4'hF, 32'h5008 + 32'(4 * k));
      checks++;
      assert (st_ready === 1'b1 && full === 1'b0 && empty === 1'b0) else begin
        errors++;
        $error("FAIL t5_steady_%0d: observed ready=%b full=%b empty=%b expected 1 0 0",
               k, st_ready, full, empty);
      end
    end
    cycles(1);
    chk("t5_one_left", 32'(empty), 32'd0);
    cycles(1);
    chk("t5_drained", 32'(empty), 32'd1);
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-drain with three queued stores
    dm_ready = 1'b0;
    do_store(32'h200, 32'hC000_0000, 4'hF, 32'h6000);
    do_store(32'h204, 32'hC000_0001, 4'hF, 32'h6004);
    do_store(32'h208, 32'hC000_0002, 4'hF, 32'h6008);
    dm_ready = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    sb.delete();
    chk("t6_dm_we",    32'(dm_we),    32'd0);
    chk("t6_empty",    32'(empty),    32'd1);
    chk("t6_st_ready", 32'(st_ready), 32'd1);
    chk("t6_dm_addr",  dm_addr,       32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycles(5);
    chk("t6_still_empty", 32'(empty), 32'd1);
    chk("t6_no_write",    32'(dm_we), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
